// File: rtl/sweep_disp_pkg.sv
// sweep_disp_pkg: shared segment encoding for the multiplexed 7-segment driver.
package sweep_disp_pkg;
  localparam int SEG_DP = 7;
  localparam logic [7:0] SEG_OFF = 8'h00;
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational 4-bit hex to active-high a..g segment decoder.
module hex_to_7seg
  import sweep_disp_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);
  assign seg = hex7(value);
endmodule

// File: rtl/sweep_ndisp7seg.sv
// sweep_ndisp7seg: multiplexed N-digit 7-segment driver with blanking, PWM dimming and frame snapshot.
module sweep_ndisp7seg
  import sweep_disp_pkg::*;
#(
  parameter int NDIGITS       = 4,
  parameter int NBITS_COMPARE = 26,
  parameter int COMPARE       = 100_000,
  parameter int DIM_BITS      = 3,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NDIGITS-1:0]   digits,
  input  logic [NDIGITS-1:0]     dp,
  input  logic                   blank_lz,
  input  logic [DIM_BITS-1:0]    brightness,
  output logic [7:0]             seg,
  output logic [NDIGITS-1:0]     dispTrans,
  output logic                   frame_tick
);
  localparam int IW = $clog2(NDIGITS);
  localparam logic [NBITS_COMPARE-1:0] CMAX = NBITS_COMPARE'(COMPARE - 1);
  localparam logic [IW-1:0] ILAST = IW'(NDIGITS - 1);
  localparam logic INV = ACTIVE_LOW != 0;
  logic [NBITS_COMPARE-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*NDIGITS-1:0] snap_digits;
  logic [NDIGITS-1:0] snap_dp, blank, an;
  logic snap_blz, primed, tick, wrap, z;
  logic [3:0] cur;
  logic [6:0] hex;
  logic [7:0] seg_n;
  assign tick = cnt == CMAX;
  assign wrap = tick && idx == ILAST;
  assign cur  = snap_digits[4*idx +: 4];
  hex_to_7seg u_hex (.value(cur), .seg(hex));
  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    blank = '0;
    z = 1'b1;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      z = z && snap_digits[4*i +: 4] == 4'h0;
      blank[i] = snap_blz && z;
    end
  end
  always_comb begin
    seg_n = SEG_OFF;
    seg_n[6:0] = blank[idx] ? 7'h00 : hex;
    seg_n[SEG_DP] = snap_dp[idx];
  end
  // cnt == 0 is the anti-ghost guard cycle at each digit switch.
  assign an = (cnt != '0 && cnt[DIM_BITS-1:0] <= brightness) ? NDIGITS'(1) << idx : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      snap_digits <= '0;
      snap_dp <= '0;
      snap_blz <= 1'b0;
      primed <= 1'b0;
      seg <= SEG_OFF ^ {8{INV}};
      dispTrans <= {NDIGITS{INV}};
      frame_tick <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx == ILAST ? '0 : idx + 1'b1;
      primed <= 1'b1;
      if (wrap || !primed) begin
        snap_digits <= digits;
        snap_dp <= dp;
        snap_blz <= blank_lz;
      end
      frame_tick <= wrap;
      seg <= seg_n ^ {8{INV}};
      dispTrans <= an ^ {NDIGITS{INV}};
    end
endmodule

// File: tb/tb_sweep_ndisp7seg.sv
// tb_sweep_ndisp7seg: table vectors, corner sequences and random stimulus against a frame-level model.
module tb_sweep_ndisp7seg;
  localparam int N = 4, C = 8, NC = N * C, DB = 2;
  logic clk = 1'b0, rst = 1'b1, blank_lz = 1'b0, frame_tick;
  logic [15:0] digits = '0;
  logic [3:0] dp = '0, dispTrans;
  logic [1:0] brightness = 2'd3;
  logic [7:0] seg;
  int tests = 0, fails = 0, e = 0;
  logic [15:0] m_d;
  logic [3:0] m_dp;
  logic m_b;
  logic [7:0] exp_seg;
  logic [3:0] exp_an;
  logic exp_ft;
  logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef struct {
    logic [15:0] d;
    logic [3:0]  p;
    logic        b;
    logic [1:0]  br;
    logic        an_on;
    logic [31:0] es;
  } vec_t;
  vec_t tbl [7];

  sweep_ndisp7seg #(.NDIGITS(N), .NBITS_COMPARE(4), .COMPARE(C), .DIM_BITS(DB), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp(dp), .blank_lz(blank_lz),
    .brightness(brightness), .seg(seg), .dispTrans(dispTrans), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at e=%0d: got %h expected %h", name, e, got, want);
    end
  endtask

  // Model: output after edge e shows slot position e-1 of the frame captured at the last frame start.
  task automatic step(input bit chk);
    int pos, c, ix;
    logic [15:0] sh;
    logic bl;
    @(posedge clk);
    e++;
    pos = e - 1;
    c = pos % C;
    ix = (pos / C) % N;
    sh = m_d >> (4 * ix);
    bl = m_b && ix > 0 && sh == 16'h0;
    exp_seg = ~{m_dp[ix], bl ? 7'h00 : tab[sh[3:0]]};
    exp_an = (c != 0 && (c % (1 << DB)) <= int'(brightness)) ? ~(4'b0001 << ix) : 4'hF;
    exp_ft = (pos % NC) == NC - 1;
    if (e == 1 || (pos % NC) == NC - 1) begin
      m_d = digits;
      m_dp = dp;
      m_b = blank_lz;
    end
    @(negedge clk);
    if (chk) begin
      check("seg", {24'h0, seg}, {24'h0, exp_seg});
      check("dispTrans", {28'h0, dispTrans}, {28'h0, exp_an});
      check("frame_tick", {31'h0, frame_tick}, {31'h0, exp_ft});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_seg", {24'h0, seg}, 32'hFF);
    check("rst_an", {28'h0, dispTrans}, 32'hF);
    check("rst_ft", {31'h0, frame_tick}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    e = 0;
    m_d = '0;
    m_dp = '0;
    m_b = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [1:0] brs [3] = '{2'd0, 2'd1, 2'd3};
    int ons [3] = '{1, 3, 7};
    tbl[0] = '{16'h1234, 4'b0000, 1'b0, 2'd3, 1'b1, 32'hF9A4B099};
    tbl[1] = '{16'h0050, 4'b0000, 1'b1, 2'd3, 1'b1, 32'hFFFF92C0};
    tbl[2] = '{16'h0050, 4'b0000, 1'b0, 2'd3, 1'b1, 32'hC0C092C0};
    tbl[3] = '{16'h0000, 4'b0100, 1'b1, 2'd3, 1'b1, 32'hFF7FFFC0};
    tbl[4] = '{16'hABCD, 4'b1001, 1'b1, 2'd0, 1'b0, 32'h0883C621};
    tbl[5] = '{16'h0F00, 4'b0000, 1'b1, 2'd1, 1'b1, 32'hFF8EC0C0};
    tbl[6] = '{16'h8000, 4'b0000, 1'b1, 2'd2, 1'b1, 32'h80C0C0C0};
    @(negedge clk);
    for (int r = 0; r < 7; r++) begin
      do_reset();
      digits = tbl[r].d;
      dp = tbl[r].p;
      blank_lz = tbl[r].b;
      brightness = tbl[r].br;
      for (int k = 0; k < NC; k++) begin
        step(1);
        if (e >= 6 && (e - 6) % C == 0) begin
          check("tbl_seg", {24'h0, seg}, {24'h0, tbl[r].es[8*((e-6)/C) +: 8]});
          check("tbl_an", {28'h0, dispTrans},
                tbl[r].an_on ? {28'h0, ~(4'b0001 << ((e-6)/C))} : 32'hF);
        end
      end
    end
    // Per-slot anode on-time for several brightness levels
    for (int b = 0; b < 3; b++) begin
      do_reset();
      brightness = brs[b];
      cnt = 0;
      for (int k = 0; k < C; k++) begin
        step(1);
        if (dispTrans != 4'hF) cnt++;
      end
      check("duty", cnt, ons[b]);
    end
    // Frame tick period
    do_reset();
    brightness = 2'd3;
    cnt = 0;
    for (int k = 0; k < 2 * NC; k++) begin
      step(1);
      if (frame_tick) cnt++;
      if (frame_tick) check("ft_pos", e % NC, 0);
    end
    check("ft_count", cnt, 2);
    // Mid-frame input change must wait for the next frame
    do_reset();
    digits = 16'h1234;
    dp = '0;
    blank_lz = 1'b0;
    while (e < 10) step(1);
    digits = 16'h5678;
    while (e < NC + C) begin
      step(1);
      if (e == 22) check("coh_d2", {24'h0, seg}, 32'hA4);
      if (e == 30) check("coh_d3", {24'h0, seg}, 32'hF9);
      if (e == NC + 6) check("coh_new_d0", {24'h0, seg}, 32'h80);
    end
    // Asynchronous reset between clock edges
    do_reset();
    digits = 16'h00C7;
    while (e < 4) step(1);
    check("pre_async_an", {28'h0, dispTrans}, 32'hE);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_seg", {24'h0, seg}, 32'hFF);
    check("async_an", {28'h0, dispTrans}, 32'hF);
    @(negedge clk);
    digits = 16'h3219;
    rst = 1'b0;
    e = 0;
    m_d = '0;
    m_dp = '0;
    m_b = 1'b0;
    for (int k = 0; k < NC; k++) begin
      step(1);
      if (e == 6) check("async_restart", {24'h0, seg}, 32'h90);
    end
    // Random stimulus against the model
    do_reset();
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        digits = 16'($urandom);
        if ($urandom_range(0, 1) == 1) digits = digits & 16'h00FF;
        dp = 4'($urandom);
        blank_lz = 1'($urandom);
      end
      if ($urandom_range(0, 31) == 0) brightness = 2'($urandom);
      step(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sweep_ndisp7seg.md
# sweep_ndisp7seg

Parametrised multiplexed 7-segment display driver: sweeps NDIGITS common-anode digits at a fixed per-digit slot period and decodes each 4-bit value to hex segment patterns. Adds per-digit decimal points, optional leading-zero blanking, PWM brightness control, a one-cycle anti-ghost guard at each digit switch and frame-coherent input snapshotting. Sits between the application datapath and the board's seg/anode pins; the board-level wrapper only maps pins.

## Interface
- NDIGITS, 4: number of digits swept (≥2)
- NBITS_COMPARE, 26: width of slot counter; must hold COMPARE-1
- COMPARE, 100_000: clk cycles per digit slot (≥ 2**DIM_BITS)
- DIM_BITS, 3: brightness resolution in bits
- ACTIVE_LOW, 1: 1 = seg and dispTrans driven active-low (Basys3), 0 = active-high
- clk  input  1  system clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- digits  input  4*NDIGITS  digit i value on [4i+3:4i]; digit 0 least significant
- dp  input  NDIGITS  decimal point request per digit
- blank_lz  input  1  1 = blank leading zeros
- brightness  input  DIM_BITS  0 = dimmest, all-ones = brightest
- seg  output  8  [6:0] = segments a..g, [7] = dp
- dispTrans  output  NDIGITS  digit enables (one-hot when active)
- frame_tick  output  1  one-cycle pulse at each frame boundary

## Operation
- Slot counter cnt: 0..COMPARE-1, increments every clk; tick = (cnt == COMPARE-1); on tick cnt←0.
- Digit index idx: advances on tick; NDIGITS-1 wraps to 0. frame_tick registered high for the cycle after tick with idx==NDIGITS-1.
- Snapshot: digits/dp/blank_lz captured into internal registers on tick with idx==NDIGITS-1, and on the first clk edge after rst deasserts (primed flag). Input changes mid-frame are not displayed until the next frame. brightness is not snapshotted; it is sampled live.
- Decode: standard hex 0–F (a..g); 0 = 0x3F, 1 = 0x06, … F = 0x71 in active-high terms.
- Leading-zero blanking: digit i (i>0) blanked when snapshot blank_lz=1 and snapshot digits i..NDIGITS-1 all zero. Digit 0 never blanked. Blanked digit: a..g off, dp still follows snapshot dp[i].
- Anode enable for idx when cnt != 0 (guard) and cnt[DIM_BITS-1:0] <= brightness. All other anodes off.
- ACTIVE_LOW=1 inverts seg and dispTrans at the output register.

## Timing
- seg, dispTrans, frame_tick registered; they reflect cnt/idx of the previous cycle (1-cycle latency).
- Reset values: cnt=0, idx=0, snapshot=0, primed=0, seg = all segments off (8'hFF when ACTIVE_LOW), dispTrans all off, frame_tick=0. Assertion mid-operation forces these immediately (asynchronous).
- Slot = COMPARE cycles; frame = NDIGITS*COMPARE cycles; frame_tick period = frame.
- Guard: first output cycle of each slot has all anodes off; two anodes never active in the same cycle.
- Brightness all-ones: anode on COMPARE-1 of COMPARE cycles; brightness b: on when low bits ≤ b, i.e. (b+1)/2**DIM_BITS duty, minus the guard cycle.
- Snapshot load and idx wrap on same edge: digit 0 of new frame uses new snapshot.

## Structure
- Package sweep_disp_pkg: hex-to-segment function/constant table, segment bit-position constants, SEG_OFF constant.
- One sub-module natural: hex_to_7seg (combinational 4-bit → 7-bit decoder, active-high), instantiated once on the selected digit.
- Top holds counters, snapshot, blanking logic, PWM compare and output registers.

## Test plan
- Reset/sweep: NDIGITS=4, COMPARE=8, DIM_BITS=2, brightness=3, digits=16'h1234, ACTIVE_LOW=1 -> after reset seg=8'hFF, dispTrans=4'hF; then dispTrans cycles 4'hE,4'hD,4'hB,4'h7 each 7 cycles on + 1 guard off; seg=~8'h06 ("4"? no: digit0=4 → ~8'h66) during digit 0.
- Leading zeros: digits=16'h0050, blank_lz=1 -> digits 3,2 seg=8'hFF (a..g and dp off), digit1 = ~8'h6D, digit0 = ~8'h3F; blank_lz=0 -> digits 3,2 show ~8'h3F.
- Decimal point: dp=4'b0100 on digits=16'h0000, blank_lz=1 -> digit 2 seg=8'h7F (only dp on), digits 3,1 = 8'hFF, digit 0 = ~8'h3F.
- Brightness: brightness=0 -> each anode on only cycles with cnt∈{4} (cnt[1:0]==0, cnt≠0), i.e. 1 of 8; brightness=1 -> cycles {1,4,5}.
- Frame coherence: change digits mid-frame (during idx=1) -> remaining digits of that frame unchanged; new value appears from next digit 0; frame_tick one pulse every 32 cycles.
- Async reset mid-slot: assert rst between clk edges -> seg/dispTrans go off without a clk edge; after release sweep restarts at digit 0 with fresh snapshot.
